func_sweep_ctrl: RTL
====================

Name: func_sweep_ctrl

Overview:
- Sequencer that exhaustively exercises a 4-input combinational function unit, such as the team's mux-based boolean block ep01C.
- Drives the unit's a, b, c and d inputs through all 16 combinations and samples the returned f after a settle delay.
- Builds the observed 16-bit truth table and compares it bit-by-bit against an expected table.
- Sits between a start/result handshake (test sequencer or top-level FSM) and the function unit under test.

Parameters:
- SETTLE, 2, cycles an input vector is held before f is sampled; legal range 1..255.
- EXPECTED, 16'hFCE8, expected truth table; bit i = f for index i = {a,b,c,d}, a = MSB. The default is ep01C's function.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  request a sweep; sampled only in IDLE.
- abort  input  1  cancel the running sweep; wins over start.
- f_in  input  1  output f of the function unit under test.
- a, b, c, d  output  1 each  registered stimulus; {a,b,c,d} = current index.
- busy  output  1  high while a sweep runs (SETTLE or SAMPLE state).
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  1 if the last completed sweep had zero mismatches.
- truth_table  output  16  observed f per index from the last/current sweep.
- mismatch_count  output  5  number of indices where f_in differed from EXPECTED (0..16).
- first_mismatch  output  4  lowest mismatching index; 0 if none.
- mismatch_valid  output  1  1 if at least one mismatch has been recorded.

Behaviour:
- Only one clock; reset_n is synchronous, active-low, and overrides all other inputs.
- Reset values: state=IDLE; a, b, c, d=0; busy=0; done=0; pass=0; truth_table=0; mismatch_count=0; first_mismatch=0; mismatch_valid=0.
- Internal registers: 4-bit idx and 8-bit settle counter cnt. a, b, c, d are driven straight from idx (registered, no combinational path from inputs).

State machine (states IDLE, SETTLE, SAMPLE, DONE):
- IDLE:
  - If start=1 and abort=0: clear truth_table, mismatch_count, first_mismatch, mismatch_valid and pass; set idx=0, cnt=0; go to SETTLE.
  - Otherwise stay. idx holds 0 in IDLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE-1, go to SAMPLE.
  - With SETTLE=1 the block spends exactly 1 cycle in SETTLE.
- SAMPLE:
  - Set truth_table[idx] <= f_in.
  - If f_in != EXPECTED[idx]: mismatch_count += 1. If mismatch_valid==0, also set first_mismatch <= idx and mismatch_valid <= 1.
  - If idx==15: go to DONE.
  - Otherwise idx <= idx+1, cnt <= 0, go to SETTLE.
  - idx never wraps during a sweep.
- DONE:
  - done=1 for exactly this cycle.
  - pass <= (mismatch_count==0), using the final, already-updated count.
  - idx <= 0; go to IDLE.

Timing:
- Each vector occupies SETTLE+1 cycles.
- With start sampled at edge T, done is high during cycle T+16*(SETTLE+1)+1.
- busy=1 exactly in SETTLE and SAMPLE.

Boundary conditions:
- start while busy or in DONE: ignored; no restart.
- abort in SETTLE or SAMPLE: the next edge goes to IDLE with idx=0. No done pulse. pass stays 0. Partial truth_table and mismatch fields are retained for debug.
- abort in IDLE or DONE: no effect, except that abort=1 blocks start.
- start and abort both high in IDLE: stay IDLE.
- reset_n low mid-sweep: all outputs return to reset values on that edge.
- Results (truth_table, pass, mismatch fields) hold stable in IDLE until the next accepted start.
- mismatch_count saturating is unnecessary: the maximum is 16, which fits in 5 bits.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with start=1 -> every output at its reset value and busy=0. After release, with start=0, the state stays IDLE.
- Golden sweep: connect f_in to the ep01C model, SETTLE=2, pulse start -> {a,b,c,d} steps 0..15, each held 3 cycles. done pulses once at cycle 49 after start. Results: truth_table=16'hFCE8, pass=1, mismatch_count=0, mismatch_valid=0.
- Stuck-at-0 fault: f_in=0 -> truth_table=16'h0000, mismatch_count=10, first_mismatch=3, mismatch_valid=1, pass=0.
- Inverted fault: f_in = ~model -> truth_table=16'h0317, mismatch_count=16, first_mismatch=0, pass=0.
- Abort and ignored start: pulse start again while busy -> no restart (done still at cycle 49). In a second run, assert abort while idx=7 -> next cycle busy=0 and a, b, c, d=0; no done pulse; pass=0. A subsequent start runs a clean full sweep.
- SETTLE=1 plus mid-sweep reset: full sweep -> done at cycle 33. Repeat with reset_n=0 at idx=9 -> all outputs cleared on that edge.

Source files
------------

// File: rtl/func_sweep_ctrl.sv
// Purpose: sweeps a 4-input combinational unit through all 16 vectors and checks its truth table.
// Latency: SETTLE+1 cycles per vector; done pulses 16*(SETTLE+1)+1 cycles after start is sampled.
// Backpressure: none; start is taken only in IDLE, abort cancels a running sweep immediately.
module func_sweep_ctrl #(
  parameter int          SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'hFCE8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] truth_table,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_mismatch,
  output logic        mismatch_valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Terminal value of the settle counter; SETTLE is limited to 1..255 so this fits 8 bits.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  idx;
  logic [7:0]  cnt;
  logic        accept;

  // Stimulus comes straight from the vector index register.
  assign {a, b, c, d} = idx;
  // A start request counts only when abort is not also asserted.
  assign accept = start && !abort;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode plus the state-derived busy/done flags.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        busy = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (idx == 4'd15) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Index, settle counter and result registers; abort keeps partial results for debug.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idx            <= 4'd0;
      cnt            <= 8'd0;
      pass           <= 1'b0;
      truth_table    <= 16'd0;
      mismatch_count <= 5'd0;
      first_mismatch <= 4'd0;
      mismatch_valid <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            idx            <= 4'd0;
            cnt            <= 8'd0;
            pass           <= 1'b0;
            truth_table    <= 16'd0;
            mismatch_count <= 5'd0;
            first_mismatch <= 4'd0;
            mismatch_valid <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            idx <= 4'd0;
            cnt <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_SAMPLE: begin
          cnt <= 8'd0;
          if (abort) begin
            idx <= 4'd0;
          end else begin
            truth_table[idx] <= f_in;
            if (f_in != EXPECTED[idx]) begin
              mismatch_count <= mismatch_count + 5'd1;
              if (!mismatch_valid) begin
                first_mismatch <= idx;
                mismatch_valid <= 1'b1;
              end
            end
            // idx stays at 15 into DONE so the last vector remains on the pins.
            if (idx != 4'd15) begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_DONE: begin
          pass <= (mismatch_count == 5'd0);
          idx  <= 4'd0;
        end
        default: begin
          idx <= 4'd0;
        end
      endcase
    end
  end

endmodule
